move_collector: RTL
===================

MOVE_COLLECTOR -- requirements
Module: move_collector

Interface
REQ-001 SHALL have parameter NPORT, default 4: number of local move stacks drained.
REQ-002 SHALL have parameter RD_LAT, default 2: cycles from a stack_read pulse to valid stack_move data, legal range 1..7.
REQ-003 SHALL have port clk, input, 1: clock; reset rst, asynchronous, active-low; clock clk.
REQ-004 SHALL have port rst, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1: permits starting new transfers.
REQ-006 SHALL have port stack_empty, input, NPORT: per-stack empty flag, bit i = stack i.
REQ-007 SHALL have port stack_read, output, NPORT: per-stack one-cycle pop pulse.
REQ-008 SHALL have port stack_move, input, 16*NPORT: per-stack move data, stack i on bits [16i+15:16i].
REQ-009 SHALL have port out_move, output, 16: collected move to the global store.
REQ-010 SHALL have port out_valid, output, 1: out_move holds a valid move.
REQ-011 SHALL have port out_ready, input, 1: global store accepts out_move this cycle.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port drained, output, 1: high when in IDLE and all stack_empty bits are 1.
REQ-014 SHALL have port move_count, output, 8: number of moves accepted since reset, saturating at 255.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WAIT, HOLD.
REQ-016 In IDLE, if enable=1 and any stack_empty bit is 0, SHALL select the first non-empty stack at or after rr_ptr, wrapping modulo NPORT, latch it as sel, and go to READ. Otherwise SHALL stay in IDLE.
REQ-017 In READ, SHALL assert stack_read[sel] for exactly one cycle, with all other bits 0, load wait counter with RD_LAT-1, and go to WAIT.
REQ-018 In WAIT, SHALL decrement the counter each cycle. At counter=0 SHALL register stack_move[sel] into out_move, set out_valid=1, and go to HOLD.
REQ-019 In HOLD, SHALL keep out_move and out_valid stable until out_ready=1.
REQ-020 On HOLD with out_ready=1, SHALL, on the next edge: clear out_valid, increment move_count (saturating), set rr_ptr=(sel+1) mod NPORT, and go to IDLE.
REQ-021 SHALL never assert more than one stack_read bit in any cycle, and SHALL never assert stack_read outside READ.
REQ-022 Minimum transfer period SHALL be RD_LAT+3 cycles per move with out_ready held at 1 (IDLE, READ, RD_LAT WAIT/capture, HOLD).
REQ-023 Deassertion of enable mid-transfer SHALL NOT abort the transfer. The move SHALL complete to IDLE, and no new transfer SHALL start.
REQ-024 A stack whose stack_empty changes to 1 after selection SHALL still complete its transfer. Data captured in that case is the data present on stack_move.
REQ-025 out_ready while out_valid=0 SHALL have no effect.
REQ-026 rr_ptr SHALL give round-robin fairness: with all stacks non-empty, stacks SHALL be served in order 0,1,..,NPORT-1,0.

Reset
REQ-027 On rst=0, SHALL, asynchronously: state=IDLE, stack_read=0, out_move=0, out_valid=0, move_count=0, rr_ptr=0, sel=0, wait counter=0.
REQ-028 Reset asserted mid-transfer SHALL discard the in-flight move without counting it. After release, operation SHALL resume from IDLE with rr_ptr=0.
REQ-029 busy SHALL be 0 during reset. drained SHALL equal the AND of all stack_empty bits during reset.

Verification
REQ-030 Scenario: NPORT=4, RD_LAT=2; stack 2 only non-empty, holding 16'hA5C3; enable=1, out_ready=1. Required: stack_read=4'b0100 for one cycle; out_valid=1 with out_move=16'hA5C3 two cycles later; move_count=1.
REQ-031 Scenario: all four stacks non-empty continuously, out_ready=1. Required: stack_read pulses in order 0001,0010,0100,1000,0001, spaced 5 cycles apart.
REQ-032 Scenario: out_ready held 0 for 10 cycles during HOLD. Required: out_move and out_valid stable throughout; no stack_read pulse; transfer completes one cycle after out_ready=1.
REQ-033 Scenario: enable dropped in the READ cycle. Required: the current move is still delivered; afterwards busy=0 and no further stack_read while enable=0.
REQ-034 Scenario: rst pulsed low during WAIT. Required: out_valid=0 and move_count=0 immediately; first pulse after release goes to the lowest non-empty stack.
REQ-035 Scenario: 300 moves accepted. Required: move_count=255 and no wrap; drained=1 once all stacks are empty and the FSM is in IDLE.

Source files
------------

// File: rtl/move_collector.sv
// Drains NPORT local move stacks one move at a time into a single global
// output, choosing stacks round-robin and waiting RD_LAT cycles for read data.
module move_collector #(
   parameter int NPORT  = 4,
   parameter int RD_LAT = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [NPORT-1:0]      stack_empty,
   output logic [NPORT-1:0]      stack_read,
   input  logic [16*NPORT-1:0]   stack_move,
   output logic [15:0]           out_move,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  drained,
   output logic [7:0]            move_count,
   output logic [1:0]            o_dbg_state
);

   localparam int SW = (NPORT > 1) ? $clog2(NPORT) : 1;
   localparam int CW = 3;

   // out_valid/out_ready: a move transfers on any edge where both are high;
   // while out_valid is high out_move is held constant, and out_ready alone
   // does nothing.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t          r_state;
   logic [SW-1:0]   r_sel;
   logic [SW-1:0]   r_rr_ptr;
   logic [CW-1:0]   r_wait_cnt;

   logic            w_found;
   logic [SW-1:0]   w_pick;
   logic [15:0]     w_sel_move;

   function automatic logic [SW-1:0] wrap_idx(input logic [SW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NPORT) s = s - NPORT;
      return SW'(s);
   endfunction

   function automatic logic [SW-1:0] next_ptr(input logic [SW-1:0] p);
      logic [SW-1:0] n;
      if (p == SW'(NPORT - 1)) n = '0;
      else                     n = p + 1'b1;
      return n;
   endfunction

   // First non-empty stack at or after the round-robin pointer.
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_rr_ptr;
      for (int k = 0; k < NPORT; k++) begin
         if (!w_found && !stack_empty[wrap_idx(r_rr_ptr, k)]) begin
            w_found = 1'b1;
            w_pick  = wrap_idx(r_rr_ptr, k);
         end
      end
   end

   always_comb begin
      w_sel_move = '0;
      for (int k = 0; k < NPORT; k++) begin
         if (r_sel == SW'(k)) w_sel_move = stack_move[16*k +: 16];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_sel      <= '0;
         r_rr_ptr   <= '0;
         r_wait_cnt <= '0;
         stack_read <= '0;
         out_move   <= '0;
         out_valid  <= 1'b0;
         move_count <= '0;
      end else begin
         stack_read <= '0;
         case (r_state)
            S_IDLE: begin
               // The pop pulse is registered so it is high exactly while in READ.
               if (enable && w_found) begin
                  r_sel      <= w_pick;
                  stack_read <= NPORT'(1) << w_pick;
                  r_state    <= S_READ;
               end
            end
            S_READ: begin
               r_wait_cnt <= CW'(RD_LAT - 1);
               r_state    <= S_WAIT;
            end
            S_WAIT: begin
               if (r_wait_cnt == '0) begin
                  out_move  <= w_sel_move;
                  out_valid <= 1'b1;
                  r_state   <= S_HOLD;
               end else begin
                  r_wait_cnt <= r_wait_cnt - 1'b1;
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (move_count != 8'hFF) move_count <= move_count + 8'd1;
                  r_rr_ptr  <= next_ptr(r_sel);
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy        = (r_state != S_IDLE);
   assign drained     = (r_state == S_IDLE) && (&stack_empty);
   assign o_dbg_state = r_state;

endmodule
